// File: rtl/rv32i_csr_pkg.sv
// Shared definitions for the machine-mode CSR command interface: command
// encodings, CSR addresses, SYSTEM opcode/funct3 values and issuer states.
package rv32i_csr_pkg;

  typedef enum logic [2:0] {
    CSR_NOP   = 3'b000,
    CSR_WRITE = 3'b001,
    CSR_SET   = 3'b010,
    CSR_CLEAR = 3'b011,
    CSR_READ  = 3'b100
  } csr_cmd_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC,
    S_RD,
    S_CAP,
    S_WR,
    S_WB,
    S_ERR
  } state_e;

  function automatic logic csr_addr_known(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/rv32i_csr_decode.sv
// Combinational decode of a latched Zicsr instruction word into the
// legality, read/write requirements, write command and operand select.
module rv32i_csr_decode
  import rv32i_csr_pkg::*;
#(
  parameter int CHECK_ADDR = 1
) (
  input  logic [31:0] instr,
  output logic        legal,
  output logic        need_rd,
  output logic        need_wr,
  output logic [2:0]  wr_cmd,
  output logic        use_imm,
  output logic        addr_ok
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1_field;
  logic       funct3_ok;
  logic       is_swap;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign rd        = instr[11:7];
  assign rs1_field = instr[19:15];

  assign funct3_ok = (funct3 == F3_CSRRW)  || (funct3 == F3_CSRRS)  ||
                     (funct3 == F3_CSRRC)  || (funct3 == F3_CSRRWI) ||
                     (funct3 == F3_CSRRSI) || (funct3 == F3_CSRRCI);

  assign addr_ok = (CHECK_ADDR == 0) || csr_addr_known(instr[31:20]);
  assign legal   = (opcode == OPC_SYSTEM) && funct3_ok && addr_ok;

  // A swap into x0 skips the read; set/clear with a zero rs1 *field* skips
  // the write, even if the register itself happens to hold a non-zero value.
  assign is_swap = (funct3[1:0] == 2'b01);
  assign need_rd = legal && !(is_swap && (rd == 5'd0));
  assign need_wr = legal && (is_swap || (rs1_field != 5'd0));
  assign use_imm = funct3[2];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_cmd = CSR_NOP;
    unique case (funct3[1:0])
      2'b01:   wr_cmd = CSR_WRITE;
      2'b10:   wr_cmd = CSR_SET;
      2'b11:   wr_cmd = CSR_CLEAR;
      default: wr_cmd = CSR_NOP;
    endcase
  end

endmodule

// File: rtl/rv32i_csr_issuer.sv
// Issues the READ and WRITE/SET/CLEAR commands of one Zicsr instruction to
// the CSR unit in read-then-write order and retires the old CSR value.
module rv32i_csr_issuer
  import rv32i_csr_pkg::*;
#(
  parameter int CHECK_ADDR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  output logic        csr_en,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic [2:0]  csr_cmd,
  input  logic [31:0] csr_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal
);

  state_e      state;
  logic [31:0] instr_q;
  logic [31:0] rs1_q;
  logic [31:0] old_val;

  logic        dec_legal;
  logic        dec_need_rd;
  logic        dec_need_wr;
  logic [2:0]  dec_wr_cmd;
  logic        dec_use_imm;
  logic        dec_addr_ok;
  logic [31:0] operand;

  rv32i_csr_decode #(
    .CHECK_ADDR (CHECK_ADDR)
  ) u_decode (
    .instr   (instr_q),
    .legal   (dec_legal),
    .need_rd (dec_need_rd),
    .need_wr (dec_need_wr),
    .wr_cmd  (dec_wr_cmd),
    .use_imm (dec_use_imm),
    .addr_ok (dec_addr_ok)
  );

  assign operand = dec_use_imm ? {27'd0, instr_q[19:15]} : rs1_q;

  // Outputs are loaded on the edge that enters a state, so each one is
  // valid exactly during the state it belongs to and never depends on inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state and outputs use non-blocking assignments so every
      // register samples the pre-edge values, whatever order they appear in.
      state       <= S_IDLE;
      instr_q     <= '0;
      rs1_q       <= '0;
      old_val     <= '0;
      instr_ready <= 1'b1;
      csr_en      <= 1'b0;
      csr_cmd     <= CSR_NOP;
      csr_addr    <= '0;
      csr_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
    end else begin
      csr_en    <= 1'b0;
      csr_cmd   <= CSR_NOP;
      csr_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      illegal   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            rs1_q       <= rs1_data;
            old_val     <= '0;
            csr_addr    <= instr[31:20];
            instr_ready <= 1'b0;
            state       <= S_DEC;
          end
        end

        S_DEC: begin
          if (!dec_legal) begin
            illegal <= 1'b1;
            state   <= S_ERR;
          end else if (dec_need_rd) begin
            csr_en  <= 1'b1;
            csr_cmd <= CSR_READ;
            state   <= S_RD;
          end else begin
            csr_en    <= 1'b1;
            csr_cmd   <= dec_wr_cmd;
            csr_wdata <= operand;
            state     <= S_WR;
          end
        end

        S_RD: begin
          state <= S_CAP;
        end

        // The CSR unit registers its read data, so it is valid here.
        S_CAP: begin
          old_val <= csr_rdata;
          if (dec_need_wr) begin
            csr_en    <= 1'b1;
            csr_cmd   <= dec_wr_cmd;
            csr_wdata <= operand;
            state     <= S_WR;
          end else begin
            wb_valid <= 1'b1;
            wb_rd    <= instr_q[11:7];
            wb_data  <= csr_rdata;
            state    <= S_WB;
          end
        end

        S_WR: begin
          wb_valid <= 1'b1;
          wb_rd    <= instr_q[11:7];
          wb_data  <= dec_need_rd ? old_val : 32'd0;
          state    <= S_WB;
        end

        S_WB, S_ERR: begin
          csr_addr    <= '0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: begin
          csr_addr    <= '0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_csr_issuer.sv
// Directed bench for rv32i_csr_issuer with a small behavioural CSR unit
// holding mstatus, mtvec, mepc and mcause.
module tb_rv32i_csr_issuer;
  import rv32i_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [2:0]  csr_cmd;
  logic [31:0] csr_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  logic [31:0] mstatus = 32'h0000_1888;
  logic [31:0] mtvec   = 32'h0000_0100;
  logic [31:0] mepc    = 32'h0000_0000;
  logic [31:0] mcause  = 32'h0000_000F;

  int n_checks = 0;
  int n_fail   = 0;

  int          n_cmd;
  logic [2:0]  cmd_log [4];
  logic [31:0] wdata_log [4];
  int          lat;
  bit          got_wb;
  bit          got_ill;
  logic [4:0]  s_rd;
  logic [31:0] s_data;
  logic        ready_after;

  always #5 clk = ~clk;

  rv32i_csr_issuer #(
    .CHECK_ADDR (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs1_data    (rs1_data),
    .csr_en      (csr_en),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_cmd     (csr_cmd),
    .csr_rdata   (csr_rdata),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .illegal     (illegal)
  );

  function automatic logic [31:0] apply_cmd(logic [31:0] cur, logic [2:0] cmd, logic [31:0] w);
    case (cmd)
      CSR_WRITE: return w;
      CSR_SET:   return cur | w;
      CSR_CLEAR: return cur & ~w;
      default:   return cur;
    endcase
  endfunction

  function automatic logic [31:0] model_read(logic [11:0] a);
    case (a)
      CSR_MSTATUS: return mstatus;
      CSR_MTVEC:   return mtvec;
      CSR_MEPC:    return mepc;
      CSR_MCAUSE:  return mcause;
      default:     return 32'd0;
    endcase
  endfunction

  // Behavioural CSR unit: registered read data, write/set/clear on the strobe.
  always @(posedge clk) begin
    if (csr_en) begin
      if (csr_cmd == CSR_READ) begin
        csr_rdata <= model_read(csr_addr);
      end else begin
        case (csr_addr)
          CSR_MSTATUS: mstatus <= apply_cmd(mstatus, csr_cmd, csr_wdata);
          CSR_MTVEC:   mtvec   <= apply_cmd(mtvec, csr_cmd, csr_wdata);
          CSR_MEPC:    mepc    <= apply_cmd(mepc, csr_cmd, csr_wdata);
          CSR_MCAUSE:  mcause  <= apply_cmd(mcause, csr_cmd, csr_wdata);
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] enc(logic [11:0] csr, logic [4:0] rs1f, logic [2:0] f3, logic [4:0] rd);
    return {csr, rs1f, f3, rd, OPC_SYSTEM};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    check({tag, "_en"},    {31'd0, csr_en},      32'd0);
    check({tag, "_cmd"},   {29'd0, csr_cmd},     32'd0);
    check({tag, "_addr"},  {20'd0, csr_addr},    32'd0);
    check({tag, "_wdata"}, csr_wdata,            32'd0);
    check({tag, "_wbv"},   {31'd0, wb_valid},    32'd0);
    check({tag, "_wbrd"},  {27'd0, wb_rd},       32'd0);
    check({tag, "_wbd"},   wb_data,              32'd0);
    check({tag, "_ill"},   {31'd0, illegal},     32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) break;
    end
    check("wait_ready", {31'd0, instr_ready}, 32'd1);
  endtask

  // Offer one instruction and watch the interface until wb_valid or illegal,
  // then sample instr_ready one cycle later.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] rs1);
    n_cmd = 0; lat = 0; got_wb = 1'b0; got_ill = 1'b0; s_rd = '0; s_data = '0;
    wait_ready();
    instr_valid = 1'b1;
    instr       = ins;
    rs1_data    = rs1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = '0;
    rs1_data    = '0;
    for (int k = 1; k <= 12; k++) begin
      if (csr_en) begin
        if (n_cmd < 4) begin
          cmd_log[n_cmd]   = csr_cmd;
          wdata_log[n_cmd] = csr_wdata;
        end
        n_cmd++;
      end
      if (wb_valid) begin
        got_wb = 1'b1; lat = k; s_rd = wb_rd; s_data = wb_data;
      end
      if (illegal) begin
        got_ill = 1'b1; lat = k;
      end
      if (got_wb || got_ill) break;
      @(negedge clk);
    end
    @(negedge clk);
    ready_after = instr_ready;
  endtask

  logic [31:0] ill_vec [3];
  int          cnt_en, cnt_wb, cnt_ill;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // CSRRW x5, mstatus, x1 : read old value, then write rs1
    run_instr(enc(CSR_MSTATUS, 5'd1, F3_CSRRW, 5'd5), 32'hA5A5_0000);
    check("rw_ncmd",  n_cmd, 2);
    check("rw_cmd0",  {29'd0, cmd_log[0]}, {29'd0, CSR_READ});
    check("rw_cmd1",  {29'd0, cmd_log[1]}, {29'd0, CSR_WRITE});
    check("rw_wdata", wdata_log[1], 32'hA5A5_0000);
    check("rw_wb",    {31'd0, got_wb}, 32'd1);
    check("rw_lat",   lat, 5);
    check("rw_rd",    {27'd0, s_rd}, 32'd5);
    check("rw_data",  s_data, 32'h0000_1888);
    check("rw_csr",   mstatus, 32'hA5A5_0000);
    check("rw_ready", {31'd0, ready_after}, 32'd1);

    // CSRRS x0, mtvec, x0 : read only
    run_instr(enc(CSR_MTVEC, 5'd0, F3_CSRRS, 5'd0), 32'hFFFF_FFFF);
    check("rs0_ncmd", n_cmd, 1);
    check("rs0_cmd0", {29'd0, cmd_log[0]}, {29'd0, CSR_READ});
    check("rs0_wb",   {31'd0, got_wb}, 32'd1);
    check("rs0_lat",  lat, 4);
    check("rs0_rd",   {27'd0, s_rd}, 32'd0);
    check("rs0_data", s_data, 32'h0000_0100);
    check("rs0_csr",  mtvec, 32'h0000_0100);

    // CSRRSI x3, mtvec, 0x1F : immediate operand, rs1 value ignored
    run_instr(enc(CSR_MTVEC, 5'h1F, F3_CSRRSI, 5'd3), 32'hDEAD_BEEF);
    check("rsi_ncmd",  n_cmd, 2);
    check("rsi_cmd1",  {29'd0, cmd_log[1]}, {29'd0, CSR_SET});
    check("rsi_wdata", wdata_log[1], 32'h0000_001F);
    check("rsi_lat",   lat, 5);
    check("rsi_rd",    {27'd0, s_rd}, 32'd3);
    check("rsi_data",  s_data, 32'h0000_0100);
    check("rsi_csr",   mtvec, 32'h0000_011F);

    // CSRRW x0, mepc, x2 : write only, no read
    run_instr(enc(CSR_MEPC, 5'd2, F3_CSRRW, 5'd0), 32'h8000_0040);
    check("wo_ncmd",  n_cmd, 1);
    check("wo_cmd0",  {29'd0, cmd_log[0]}, {29'd0, CSR_WRITE});
    check("wo_wdata", wdata_log[0], 32'h8000_0040);
    check("wo_wb",    {31'd0, got_wb}, 32'd1);
    check("wo_lat",   lat, 3);
    check("wo_data",  s_data, 32'd0);
    check("wo_csr",   mepc, 32'h8000_0040);

    // CSRRCI x7, mcause, 3
    run_instr(enc(CSR_MCAUSE, 5'd3, F3_CSRRCI, 5'd7), 32'hFFFF_FFFF);
    check("rci_ncmd",  n_cmd, 2);
    check("rci_cmd0",  {29'd0, cmd_log[0]}, {29'd0, CSR_READ});
    check("rci_cmd1",  {29'd0, cmd_log[1]}, {29'd0, CSR_CLEAR});
    check("rci_wdata", wdata_log[1], 32'h0000_0003);
    check("rci_rd",    {27'd0, s_rd}, 32'd7);
    check("rci_data",  s_data, 32'h0000_000F);
    check("rci_csr",   mcause, 32'h0000_000C);

    // Illegal: funct3=100, non-SYSTEM opcode, unknown address 0x7C0
    ill_vec[0] = enc(CSR_MSTATUS, 5'd1, 3'b100, 5'd1);
    ill_vec[1] = {CSR_MSTATUS, 5'd1, F3_CSRRW, 5'd1, 7'b0110011};
    ill_vec[2] = enc(12'h7C0, 5'd1, F3_CSRRW, 5'd1);
    for (int i = 0; i < 3; i++) begin
      run_instr(ill_vec[i], 32'h1234_5678);
      check($sformatf("ill%0d_flag", i),  {31'd0, got_ill}, 32'd1);
      check($sformatf("ill%0d_wb", i),    {31'd0, got_wb}, 32'd0);
      check($sformatf("ill%0d_ncmd", i),  n_cmd, 0);
      check($sformatf("ill%0d_ready", i), {31'd0, ready_after}, 32'd1);
    end
    check("ill_csr", mstatus, 32'hA5A5_0000);

    // Reset during CAP of CSRRS x4, mstatus, x2 : the SET must never issue
    wait_ready();
    instr_valid = 1'b1;
    instr       = enc(CSR_MSTATUS, 5'd2, F3_CSRRS, 5'd4);
    rs1_data    = 32'h0000_000F;
    @(posedge clk);
    @(negedge clk);             // DEC
    instr_valid = 1'b0;
    instr       = '0;
    rs1_data    = '0;
    @(negedge clk);             // RD
    check("abort_rd_en",  {31'd0, csr_en}, 32'd1);
    check("abort_rd_cmd", {29'd0, csr_cmd}, {29'd0, CSR_READ});
    @(negedge clk);             // CAP
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    cnt_en = 0; cnt_wb = 0; cnt_ill = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (csr_en)   cnt_en++;
      if (wb_valid) cnt_wb++;
      if (illegal)  cnt_ill++;
    end
    check("abort_no_en",  cnt_en, 0);
    check("abort_no_wb",  cnt_wb, 0);
    check("abort_no_ill", cnt_ill, 0);
    check("abort_csr",    mstatus, 32'hA5A5_0000);

    // CSRRW x6, mepc, x9 after the abort completes normally
    run_instr(enc(CSR_MEPC, 5'd9, F3_CSRRW, 5'd6), 32'h0000_1234);
    check("post_ncmd", n_cmd, 2);
    check("post_lat",  lat, 5);
    check("post_rd",   {27'd0, s_rd}, 32'd6);
    check("post_data", s_data, 32'h8000_0040);
    check("post_csr",  mepc, 32'h0000_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
